// File: rtl/fractal_stream_rx_if.sv
// Pixel stream bundle: tdata/tuser/tlast/tvalid forward, tready backward.
// Latency: none, wires only.
// Backpressure: master holds tdata/tuser/tlast while tvalid=1 and tready=0.
interface fractal_stream_rx_if #(
  parameter int DW = 8
);
  logic [DW-1:0] tdata;
  logic          tuser;
  logic          tlast;
  logic          tvalid;
  logic          tready;

  modport master (
    output tdata, tuser, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tuser, tlast, tvalid,
    output tready
  );
endinterface

// File: rtl/fractal_stream_rx.sv
// Fractal pixel sink: framing check, palette lookup to RGB, output FIFO to a backpressured stream.
// Latency: input beat at cycle N -> output valid at N+2 when the FIFO is empty.
// Backpressure: input never stalls; a full FIFO drops the beat, flags overflow and resyncs at next SOF.

// Generic FIFO with a registered head; capacity DEPTH counting the head entry.
// Latency: push into an empty FIFO is visible on o_vld the next cycle.
// Backpressure: push accepted when not full or when a pop happens in the same cycle.
module fractal_stream_rx_fifo #(
  parameter int DW    = 26,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_push_vld,
  input  logic [DW-1:0] i_push_dat,
  output logic          o_push_ok,
  output logic          o_vld,
  output logic [DW-1:0] o_dat,
  input  logic          i_rdy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Backing store only ever holds DEPTH-1 entries; the head register holds the last one.
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_mem_cnt;
  logic          r_head_vld;
  logic [DW-1:0] r_head_dat;

  logic          w_pop;
  logic [AW:0]   w_cnt;
  logic          w_head_load;
  logic          w_from_mem;
  logic          w_bypass;
  logic          w_mem_wr;

  assign w_pop       = r_head_vld & i_rdy;
  assign w_cnt       = r_mem_cnt + (AW+1)'(r_head_vld);
  assign o_push_ok   = i_push_vld & ((w_cnt != FULL_CNT) | w_pop);
  assign w_head_load = ~r_head_vld | w_pop;
  assign w_from_mem  = w_head_load & (r_mem_cnt != '0);
  assign w_bypass    = w_head_load & (r_mem_cnt == '0) & o_push_ok;
  assign w_mem_wr    = o_push_ok & ~w_bypass;

  assign o_vld = r_head_vld;
  assign o_dat = r_head_dat;

  // Head register refill and pointer/count bookkeeping.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_head_vld <= 1'b0;
      r_head_dat <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_mem_cnt  <= '0;
    end else begin
      if (w_head_load) begin
        r_head_vld <= w_from_mem | w_bypass;
        if (w_from_mem) begin
          r_head_dat <= r_mem[r_rd_ptr];
        end else if (w_bypass) begin
          r_head_dat <= i_push_dat;
        end
      end
      if (w_from_mem) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_mem_wr)   r_wr_ptr <= r_wr_ptr + 1'b1;
      r_mem_cnt <= r_mem_cnt + (AW+1)'(w_mem_wr) - (AW+1)'(w_from_mem);
    end
  end

  // Storage write; contents need no reset since the count gates every read.
  always_ff @(posedge clk) begin
    if (w_mem_wr) r_mem[r_wr_ptr] <= i_push_dat;
  end
endmodule

module fractal_stream_rx #(
  parameter int FIFO_DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [15:0]          i_width,
  input  logic [15:0]          i_height,
  fractal_stream_rx_if.slave   s_axis,
  input  logic                 i_pal_we,
  input  logic [7:0]           i_pal_addr,
  input  logic [23:0]          i_pal_wdata,
  fractal_stream_rx_if.master  m_axis,
  output logic                 o_err_framing,
  output logic                 o_err_overflow,
  input  logic                 i_err_clear,
  output logic [15:0]          o_frame_count
);
  typedef enum logic [0:0] {ST_SEEK, ST_FRAME} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_x, r_y, r_w, r_h;
  logic [15:0] w_x_nxt, w_y_nxt, w_w_nxt, w_h_nxt;

  logic        w_restart;
  logic        w_accept;
  logic        w_take;
  logic        w_frm_err;
  logic        w_drop_err;
  logic [15:0] w_px_w, w_px_h, w_px_x, w_px_y;
  logic        w_px_xlast, w_px_ylast;

  logic [23:0] r_pal [256];
  logic        r_s1_vld;
  logic        r_s1_tuser;
  logic        r_s1_tlast;
  logic        r_s1_eof;
  logic [23:0] r_s1_rgb;

  logic        w_push_ok;
  logic        w_push_fail;
  logic        w_head_vld;
  logic [25:0] w_head_dat;

  logic        r_err_framing;
  logic        r_err_overflow;
  logic [15:0] r_frame_count;

  // The input has no way to stall the source.
  assign s_axis.tready = 1'b1;

  assign w_push_fail = r_s1_vld & ~w_push_ok;

  // Framing state register and pixel counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_SEEK;
      r_x     <= '0;
      r_y     <= '0;
      r_w     <= '0;
      r_h     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_w     <= w_w_nxt;
      r_h     <= w_h_nxt;
    end
  end

  // Classify each beat, compute its pixel position and advance the counters.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_w_nxt     = r_w;
    w_h_nxt     = r_h;
    w_restart   = 1'b0;
    w_accept    = 1'b0;
    w_frm_err   = 1'b0;
    w_drop_err  = 1'b0;

    case (r_state)
      ST_SEEK: begin
        if (s_axis.tvalid && s_axis.tuser) begin
          w_restart = 1'b1;
          w_accept  = 1'b1;
        end
      end
      ST_FRAME: begin
        if (s_axis.tvalid) begin
          if (s_axis.tuser) begin
            // Early SOF: the new frame wins, the old one is abandoned.
            w_restart = 1'b1;
            w_accept  = 1'b1;
            w_frm_err = 1'b1;
          end else if (s_axis.tlast != (r_x == r_w - 16'd1)) begin
            w_frm_err  = 1'b1;
            w_drop_err = 1'b1;
          end else begin
            w_accept = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_SEEK;
    endcase

    // A restart makes this beat pixel (0,0) of a frame with freshly sampled geometry.
    w_px_w     = w_restart ? i_width  : r_w;
    w_px_h     = w_restart ? i_height : r_h;
    w_px_x     = w_restart ? 16'd0    : r_x;
    w_px_y     = w_restart ? 16'd0    : r_y;
    w_px_xlast = (w_px_x == w_px_w - 16'd1);
    w_px_ylast = (w_px_y == w_px_h - 16'd1);

    if (w_drop_err) begin
      w_state_nxt = ST_SEEK;
      w_x_nxt     = '0;
      w_y_nxt     = '0;
    end

    if (w_accept) begin
      w_w_nxt = w_px_w;
      w_h_nxt = w_px_h;
      if (w_px_xlast && w_px_ylast) begin
        w_state_nxt = ST_SEEK;
        w_x_nxt     = '0;
        w_y_nxt     = '0;
      end else begin
        w_state_nxt = ST_FRAME;
        if (w_px_xlast) begin
          w_x_nxt = '0;
          w_y_nxt = w_px_y + 16'd1;
        end else begin
          w_x_nxt = w_px_x + 16'd1;
          w_y_nxt = w_px_y;
        end
      end
    end

    // An overflow poisons the frame in flight, including the beat arriving now.
    w_take = w_accept & ~w_push_fail;
    if (w_push_fail) begin
      w_state_nxt = ST_SEEK;
      w_x_nxt     = '0;
      w_y_nxt     = '0;
    end
  end

  // Palette writes; the table is loaded by software and never reset.
  always_ff @(posedge clk) begin
    if (i_pal_we) r_pal[i_pal_addr] <= i_pal_wdata;
  end

  // Registered palette read; a same-cycle write to the same entry returns the old colour.
  always_ff @(posedge clk) begin
    r_s1_rgb <= r_pal[s_axis.tdata];
  end

  // Stage 1 sideband for the beat whose colour is being read.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_s1_vld   <= 1'b0;
      r_s1_tuser <= 1'b0;
      r_s1_tlast <= 1'b0;
      r_s1_eof   <= 1'b0;
    end else begin
      r_s1_vld   <= w_take;
      r_s1_tuser <= (w_px_x == 16'd0) && (w_px_y == 16'd0);
      r_s1_tlast <= w_px_xlast;
      r_s1_eof   <= w_px_xlast & w_px_ylast;
    end
  end

  fractal_stream_rx_fifo #(
    .DW    (26),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .i_push_vld (r_s1_vld),
    .i_push_dat ({r_s1_rgb, r_s1_tuser, r_s1_tlast}),
    .o_push_ok  (w_push_ok),
    .o_vld      (w_head_vld),
    .o_dat      (w_head_dat),
    .i_rdy      (m_axis.tready)
  );

  assign m_axis.tvalid = w_head_vld;
  assign m_axis.tdata  = w_head_dat[25:2];
  assign m_axis.tuser  = w_head_dat[1];
  assign m_axis.tlast  = w_head_dat[0];

  // Sticky error flags (clear wins over a same-cycle set) and completed-frame counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_err_framing  <= 1'b0;
      r_err_overflow <= 1'b0;
      r_frame_count  <= '0;
    end else begin
      r_err_framing  <= i_err_clear ? 1'b0 : (r_err_framing  | w_frm_err);
      r_err_overflow <= i_err_clear ? 1'b0 : (r_err_overflow | w_push_fail);
      if (w_push_ok && r_s1_eof) r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign o_err_framing  = r_err_framing;
  assign o_err_overflow = r_err_overflow;
  assign o_frame_count  = r_frame_count;
endmodule
